// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and widths for the game control blocks
// Purpose : common typedefs and constants used by the player-life controller.
// Contents: state_t (ST_IDLE/ST_PLAY/ST_INVUL/ST_OVER), DEF_LIFE_W.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_INVUL = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int DEF_LIFE_W = 3;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - 1-bit rising-edge detector
// Purpose : flags the cycle in which din is high but was low on the previous edge.
// Ports   : clk   in  clock
//           rst_n in  asynchronous active-low reset
//           din   in  level input
//           rise  out din & ~din_delayed (combinational from the registered history)
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/reimu_life_ctrl.sv
// rtl/reimu_life_ctrl.sv - player lives, respawn, invulnerability and game-over control
// Purpose : accepts hits from the collision stage, decrements lives, requests respawn,
//           runs a blinking invulnerability window and declares game over.
// Ports   : clk22     in  game tick clock
//           rst_n     in  asynchronous active-low reset
//           start     in  pulse, begin new game (IDLE/OVER only)
//           pause     in  level, freezes timers and ignores hits
//           shot      in  level, player overlapped by an enemy bullet
//           lives     out remaining lives
//           invul     out invulnerability window active
//           visible   out sprite draw enable (blinks while invulnerable)
//           respawn   out single-cycle request to return the player to spawn
//           game_over out high in OVER
//           hit_count out accepted hits this game, saturating at 255
//           state     out IDLE=0, PLAY=1, INVUL=2, OVER=3
module reimu_life_ctrl
  import game_pkg::*;
#(
  parameter int INIT_LIVES  = 3,
  parameter int LIFE_W      = DEF_LIFE_W,
  parameter int INV_TICKS   = 48,
  parameter int BLINK_TICKS = 4
) (
  input  logic              clk22,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              shot,
  output logic [LIFE_W-1:0] lives,
  output logic              invul,
  output logic              visible,
  output logic              respawn,
  output logic              game_over,
  output logic [7:0]        hit_count,
  output logic [1:0]        state
);

  localparam int INV_W   = $clog2(INV_TICKS);
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INV_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(INIT_LIVES);
  localparam logic [LIFE_W-1:0]  LIFE_ONE   = LIFE_W'(1);

  state_t               state_q, state_n;
  logic [LIFE_W-1:0]    lives_n;
  logic                 invul_n, visible_n, respawn_n, game_over_n;
  logic [7:0]           hit_count_n;
  logic [INV_W-1:0]     inv_cnt, inv_cnt_n;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_n;
  logic                 hit;

  // shot history keeps updating during pause, so an edge arriving while
  // paused is consumed rather than deferred to the unpaused cycle.
  edge_rise u_shot_edge (
    .clk  (clk22),
    .rst_n(rst_n),
    .din  (shot),
    .rise (hit)
  );

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lives     <= '0;
      invul     <= 1'b0;
      visible   <= 1'b0;
      respawn   <= 1'b0;
      game_over <= 1'b0;
      hit_count <= 8'd0;
      inv_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      state_q   <= state_n;
      lives     <= lives_n;
      invul     <= invul_n;
      visible   <= visible_n;
      respawn   <= respawn_n;
      game_over <= game_over_n;
      hit_count <= hit_count_n;
      inv_cnt   <= inv_cnt_n;
      blink_cnt <= blink_cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    lives_n     = lives;
    invul_n     = invul;
    visible_n   = visible;
    respawn_n   = 1'b0;
    game_over_n = game_over;
    hit_count_n = hit_count;
    inv_cnt_n   = inv_cnt;
    blink_cnt_n = blink_cnt;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        // start has priority; a coincident hit is simply dropped
        if (start) begin
          state_n     = ST_PLAY;
          lives_n     = LIVES_INIT;
          hit_count_n = 8'd0;
          game_over_n = 1'b0;
          invul_n     = 1'b0;
          visible_n   = 1'b1;
          respawn_n   = 1'b1;
        end
      end

      ST_PLAY: begin
        if (hit && !pause) begin
          if (hit_count != 8'hFF) begin
            hit_count_n = hit_count + 8'd1;
          end
          visible_n = 1'b0;
          if (lives == LIFE_ONE) begin
            lives_n     = '0;
            state_n     = ST_OVER;
            game_over_n = 1'b1;
          end else begin
            lives_n     = lives - LIFE_ONE;
            state_n     = ST_INVUL;
            invul_n     = 1'b1;
            inv_cnt_n   = INV_LOAD;
            blink_cnt_n = BLINK_LOAD;
            respawn_n   = 1'b1;
          end
        end
      end

      ST_INVUL: begin
        if (!pause) begin
          if (inv_cnt == '0) begin
            state_n   = ST_PLAY;
            invul_n   = 1'b0;
            visible_n = 1'b1;
          end else begin
            inv_cnt_n = inv_cnt - INV_W'(1);
            if (blink_cnt == '0) begin
              visible_n   = ~visible;
              blink_cnt_n = BLINK_LOAD;
            end else begin
              blink_cnt_n = blink_cnt - BLINK_W'(1);
            end
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_reimu_life_ctrl.sv
// tb/tb_reimu_life_ctrl.sv - directed table-driven bench for reimu_life_ctrl
module tb_reimu_life_ctrl;

  logic       clk22 = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       shot  = 1'b0;
  logic [2:0] lives;
  logic       invul, visible, respawn, game_over;
  logic [7:0] hit_count;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk22 = ~clk22;

  reimu_life_ctrl dut (
    .clk22    (clk22),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .shot     (shot),
    .lives    (lives),
    .invul    (invul),
    .visible  (visible),
    .respawn  (respawn),
    .game_over(game_over),
    .hit_count(hit_count),
    .state    (state)
  );

  typedef struct {
    logic       start, pause, shot;
    int         n;
    logic [2:0] lives;
    logic       invul, visible, respawn, game_over;
    logic [7:0] hc;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic s, logic p, logic sh, int n, logic [2:0] l,
                              logic iv, logic vi, logic rs, logic go,
                              logic [7:0] hc, logic [1:0] st);
    vec_t v;
    v.start = s; v.pause = p; v.shot = sh; v.n = n; v.lives = l;
    v.invul = iv; v.visible = vi; v.respawn = rs; v.game_over = go;
    v.hc = hc; v.st = st;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk22);
    #1;
  endtask

  task automatic chk_all(string tag, int l, int iv, int vi, int rs, int go, int hc, int st);
    chk({tag, ".lives"},     int'(lives),     l);
    chk({tag, ".invul"},     int'(invul),     iv);
    chk({tag, ".visible"},   int'(visible),   vi);
    chk({tag, ".respawn"},   int'(respawn),   rs);
    chk({tag, ".game_over"}, int'(game_over), go);
    chk({tag, ".hit_count"}, int'(hit_count), hc);
    chk({tag, ".state"},     int'(state),     st);
  endtask

  initial begin
    int cnt;
    int bound;
    logic vis_hold;

    //            st p  sh n   lv iv vi rs go hc  state
    tbl[0]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0,  0);
    tbl[1]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 0,  0); // hit in IDLE ignored
    tbl[2]  = mk(1, 0, 0, 1,  3, 0, 1, 1, 0, 0,  1); // start
    tbl[3]  = mk(0, 0, 0, 1,  3, 0, 1, 0, 0, 0,  1);
    tbl[4]  = mk(0, 0, 1, 1,  2, 1, 0, 1, 0, 1,  2); // first hit
    tbl[5]  = mk(0, 0, 1, 9,  2, 1, 0, 0, 0, 1,  2); // held: k+9, visible 0 again
    tbl[6]  = mk(0, 0, 0, 1,  2, 1, 0, 0, 0, 1,  2); // k+10
    tbl[7]  = mk(0, 0, 1, 1,  2, 1, 0, 0, 0, 1,  2); // k+11 edge during INVUL ignored
    tbl[8]  = mk(0, 0, 0, 37, 2, 0, 1, 0, 0, 1,  1); // k+48 back to PLAY
    tbl[9]  = mk(0, 0, 1, 60, 1, 0, 1, 0, 0, 2,  1); // held 60 cycles: one hit only
    tbl[10] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 2,  1);
    tbl[11] = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 3,  3); // last life -> OVER, no respawn
    tbl[12] = mk(0, 0, 0, 3,  0, 0, 0, 0, 1, 3,  3);
    tbl[13] = mk(1, 0, 1, 1,  3, 0, 1, 1, 0, 0,  1); // start+hit in OVER: start wins
    tbl[14] = mk(0, 0, 0, 1,  3, 0, 1, 0, 0, 0,  1);
    tbl[15] = mk(1, 0, 0, 1,  3, 0, 1, 0, 0, 0,  1); // start in PLAY ignored
    tbl[16] = mk(0, 1, 1, 1,  3, 0, 1, 0, 0, 0,  1); // edge during pause ignored
    tbl[17] = mk(0, 0, 1, 1,  3, 0, 1, 0, 0, 0,  1); // ...and not deferred
    tbl[18] = mk(0, 0, 0, 1,  3, 0, 1, 0, 0, 0,  1);

    // reset, checked before any clock edge while rst_n is low
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start;
      pause = tbl[i].pause;
      shot  = tbl[i].shot;
      for (int c = 0; c < tbl[i].n; c++) begin
        step();
        if (c == 0) start = 1'b0;
      end
      chk_all($sformatf("v%0d", i), int'(tbl[i].lives), int'(tbl[i].invul),
              int'(tbl[i].visible), int'(tbl[i].respawn), int'(tbl[i].game_over),
              int'(tbl[i].hc), int'(tbl[i].st));
    end
    start = 1'b0; pause = 1'b0; shot = 1'b0;

    // invulnerability window cycle by cycle: 48 cycles, blink every 4
    shot = 1'b1;
    for (int i = 0; i <= 48; i++) begin
      step();
      shot = 1'b0;
      chk($sformatf("win%0d.invul", i), int'(invul), (i < 48) ? 1 : 0);
      chk($sformatf("win%0d.visible", i), int'(visible), (i >= 48) ? 1 : ((i / 4) % 2));
      if (i <= 1) chk($sformatf("win%0d.respawn", i), int'(respawn), (i == 0) ? 1 : 0);
    end
    chk("win.state", int'(state), 1);
    chk("win.lives", int'(lives), 2);
    chk("win.hit_count", int'(hit_count), 1);

    // pause for 20 cycles inside the window stretches it to 68
    cnt = 0;
    shot = 1'b1;
    step();
    shot = 1'b0;
    chk("pz.lives", int'(lives), 1);
    chk("pz.state", int'(state), 2);
    if (invul) cnt++;
    for (int i = 0; i < 9; i++) begin
      step();
      if (invul) cnt++;
    end
    pause = 1'b1;
    vis_hold = visible;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) shot = 1'b1;
      if (i == 6) shot = 1'b0;
      step();
      if (invul) cnt++;
    end
    chk("pz.visible_frozen", int'(visible), int'(vis_hold));
    chk("pz.state_paused", int'(state), 2);
    pause = 1'b0;
    bound = 0;
    while (invul && bound < 200) begin
      step();
      bound++;
      if (invul) cnt++;
    end
    chk("pz.bound", (bound < 200) ? 1 : 0, 1);
    chk("pz.invul_cycles", cnt, 68);
    chk("pz.state_after", int'(state), 1);
    chk("pz.lives_after", int'(lives), 1);
    chk("pz.hit_count_after", int'(hit_count), 2);
    chk("pz.visible_after", int'(visible), 1);

    // finish the game, restart, and reset in the middle of a window
    shot = 1'b1;
    step();
    shot = 1'b0;
    chk_all("over", 0, 0, 0, 0, 1, 3, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("restart", 3, 0, 1, 1, 0, 0, 1);
    step();
    shot = 1'b1;
    step();
    shot = 1'b0;
    chk_all("hit2", 2, 1, 0, 1, 0, 1, 2);
    repeat (27) step();
    chk("midrst.invul_pre", int'(invul), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk22);
    #1;
    rst_n = 1'b1;
    step();
    chk_all("postrst", 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
